// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: width codes, default depth and
// the word-address compare used for load/store overlap detection.
package store_buffer_pkg;

    localparam int DEPTH_DEFAULT = 4;

    localparam logic [1:0] CON_WORD = 2'd0;
    localparam logic [1:0] CON_HALF = 2'd1;
    localparam logic [1:0] CON_BYTE = 2'd2;
    localparam logic [1:0] CON_BAD  = 2'd3;

    // Two byte addresses overlap when they fall in the same 32-bit word of
    // the 8 KiB data memory window.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[12:2] == b[12:2];
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry array holding pending stores, with read/write pointers and
// an occupancy count. Exposes per-slot valid bits and addresses so the
// parent can check pending stores against an incoming load.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_data,
    input  logic [1:0]                i_con,
    input  logic                      i_pop,
    output logic [31:0]               o_head_addr,
    output logic [31:0]               o_head_data,
    output logic [1:0]                o_head_con,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [DEPTH-1:0]          o_slot_valid,
    output logic [DEPTH*32-1:0]       o_slot_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [1:0]    r_con  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != FULL);
    assign w_do_pop  = i_pop && (r_count != '0);

    // Pointer and occupancy bookkeeping; the only state cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload write at the tail slot.
    // NOTE: the payload array has no reset; slot validity comes only from the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
            r_con[r_wr_ptr]  <= i_con;
        end
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_con  = r_con[r_rd_ptr];
    assign o_count     = r_count;

    // A slot is live when its distance from the head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] w_off;
        assign w_off                    = PW'(g) - r_rd_ptr;
        assign o_slot_valid[g]          = {1'b0, w_off} < r_count;
        assign o_slot_addr[g*32 +: 32]  = r_addr[g];
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the pipeline and data memory. Stores are queued and
// drained in order whenever the memory port is not taken by a load; loads
// that overlap a pending (or same-cycle) store are stalled until it drains.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      st_valid,
    input  logic [31:0]               st_addr,
    input  logic [31:0]               st_data,
    input  logic [1:0]                st_con,
    output logic                      st_ready,
    input  logic                      ld_valid,
    input  logic [31:0]               ld_addr,
    output logic                      ld_stall,
    output logic [31:0]               MemAddr,
    output logic [31:0]               Memdata,
    output logic                      MemWrite,
    output logic [1:0]                dmCon,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      st_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_load_go;
    logic                w_hit;
    logic [31:0]         w_head_addr;
    logic [31:0]         w_head_data;
    logic [1:0]          w_head_con;
    logic [DEPTH-1:0]    w_slot_valid;
    logic [DEPTH*32-1:0] w_slot_addr;
    logic                r_st_err;

    // Full means full: no same-cycle bypass even when a drain is happening.
    assign st_ready  = count < CW'(DEPTH);
    assign empty     = (count == '0);
    assign w_accept  = st_valid && st_ready;
    assign w_push    = w_accept && (st_con != CON_BAD);
    assign ld_stall  = ld_valid && w_hit;
    assign w_load_go = ld_valid && !ld_stall;
    assign w_pop     = !w_load_go && !empty;
    assign st_err    = r_st_err;

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk          (Clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_addr       (st_addr),
        .i_data       (st_data),
        .i_con        (st_con),
        .i_pop        (w_pop),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_head_con   (w_head_con),
        .o_count      (count),
        .o_slot_valid (w_slot_valid),
        .o_slot_addr  (w_slot_addr)
    );

    // Load overlap check against every live entry plus the one entering now.
    // NOTE: the default assignment first keeps this purely combinational;
    // without it a missed path would infer a latch.
    always_comb begin
        w_hit = 1'b0;
        if (w_push && word_match(st_addr, ld_addr)) w_hit = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_valid[i] && word_match(w_slot_addr[i*32 +: 32], ld_addr)) w_hit = 1'b1;
        end
    end

    // Memory port mux: an unstalled load has priority, else drain the head.
    always_comb begin
        MemAddr  = '0;
        Memdata  = '0;
        MemWrite = 1'b0;
        dmCon    = CON_WORD;
        if (w_load_go) begin
            MemAddr = ld_addr;
        end else if (w_pop) begin
            MemAddr  = w_head_addr;
            Memdata  = w_head_data;
            dmCon    = w_head_con;
            MemWrite = 1'b1;
        end
    end

    // One-cycle error flag for an accepted store with an invalid width code.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) r_st_err <= 1'b0;
        else        r_st_err <= w_accept && (st_con == CON_BAD);
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a table of per-cycle vectors with
// hand-computed outputs, followed by hand-written reset sequences.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_con;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic [31:0] MemAddr;
    logic [31:0] Memdata;
    logic        MemWrite;
    logic [1:0]  dmCon;
    logic        empty;
    logic [2:0]  count;
    logic        st_err;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_con   (st_con),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_stall (ld_stall),
        .MemAddr  (MemAddr),
        .Memdata  (Memdata),
        .MemWrite (MemWrite),
        .dmCon    (dmCon),
        .empty    (empty),
        .count    (count),
        .st_err   (st_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [1:0]  sc;
        logic        lv;
        logic [31:0] la;
        logic        rdy;
        logic        stall;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [1:0]  dc;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mkv(
        input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] sc,
        input logic lv, input logic [31:0] la,
        input logic rdy, input logic stall, input logic mw, input logic [31:0] ma,
        input logic [31:0] md, input logic [1:0] dc, input logic [2:0] cnt, input logic err);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sc = sc; v.lv = lv; v.la = la;
        v.rdy = rdy; v.stall = stall; v.mw = mw; v.ma = ma; v.md = md;
        v.dc = dc; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_con = CON_WORD;
        ld_valid = 1'b0; ld_addr = '0;
    endtask

    // Apply one vector after the falling edge and check the outputs it
    // produces before the next rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge Clk);
        st_valid = v.sv; st_addr = v.sa; st_data = v.sd; st_con = v.sc;
        ld_valid = v.lv; ld_addr = v.la;
        #2;
        check($sformatf("v%0d st_ready", idx), 32'(st_ready), 32'(v.rdy));
        check($sformatf("v%0d ld_stall", idx), 32'(ld_stall), 32'(v.stall));
        check($sformatf("v%0d MemWrite", idx), 32'(MemWrite), 32'(v.mw));
        check($sformatf("v%0d MemAddr", idx), MemAddr, v.ma);
        check($sformatf("v%0d Memdata", idx), Memdata, v.md);
        check($sformatf("v%0d dmCon", idx), 32'(dmCon), 32'(v.dc));
        check($sformatf("v%0d count", idx), 32'(count), 32'(v.cnt));
        check($sformatf("v%0d empty", idx), 32'(empty), 32'(v.cnt == 3'd0));
        check($sformatf("v%0d st_err", idx), 32'(st_err), 32'(v.err));
    endtask

    localparam logic [31:0] FAR = 32'h0000_1000;

    initial begin
        //            sv  st_addr       st_data       con lv  ld_addr   | rdy stl mw MemAddr       Memdata       dc cnt err
        // single word store drains on the following cycle
        vecs[0]  = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mkv(1, 32'h10,       32'hDEADBEEF, 0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[2]  = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h10,       32'hDEADBEEF, 0, 1, 0);
        vecs[3]  = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        // five back-to-back stores under a continuous non-matching load
        vecs[4]  = mkv(1, 32'h100,      32'h1,        0,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 0, 0);
        vecs[5]  = mkv(1, 32'h104,      32'h2,        0,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 1, 0);
        vecs[6]  = mkv(1, 32'h108,      32'h3,        0,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 2, 0);
        vecs[7]  = mkv(1, 32'h10C,      32'h4,        0,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 3, 0);
        vecs[8]  = mkv(1, 32'h110,      32'h5,        0,  1,  FAR,        0, 0, 0, FAR,          32'h0,        0, 4, 0);
        vecs[9]  = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      0, 0, 1, 32'h100,      32'h1,        0, 4, 0);
        vecs[10] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h104,      32'h2,        0, 3, 0);
        vecs[11] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h108,      32'h3,        0, 2, 0);
        vecs[12] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h10C,      32'h4,        0, 1, 0);
        vecs[13] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        // fill again, then push while full and draining: push refused
        vecs[14] = mkv(1, 32'h200,      32'h11,       1,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 0, 0);
        vecs[15] = mkv(1, 32'h204,      32'h22,       1,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 1, 0);
        vecs[16] = mkv(1, 32'h208,      32'h33,       2,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 2, 0);
        vecs[17] = mkv(1, 32'h20C,      32'h44,       0,  1,  FAR,        1, 0, 0, FAR,          32'h0,        0, 3, 0);
        vecs[18] = mkv(1, 32'h300,      32'h99,       0,  0,  32'h0,      0, 0, 1, 32'h200,      32'h11,       1, 4, 0);
        vecs[19] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h204,      32'h22,       1, 3, 0);
        // invalid width code is dropped and flagged for one cycle
        vecs[20] = mkv(1, 32'h400,      32'h55,       3,  0,  32'h0,      1, 0, 1, 32'h208,      32'h33,       2, 2, 0);
        vecs[21] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 1, 32'h20C,      32'h44,       0, 1, 1);
        vecs[22] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        // load to the word of a same-cycle byte store stalls until it drains
        vecs[23] = mkv(1, 32'h23,       32'hAB,       2,  1,  32'h20,     1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[24] = mkv(0, 32'h0,        32'h0,        0,  1,  32'h20,     1, 1, 1, 32'h23,       32'hAB,       2, 1, 0);
        vecs[25] = mkv(0, 32'h0,        32'h0,        0,  1,  32'h20,     1, 0, 0, 32'h20,       32'h0,        0, 0, 0);
        vecs[26] = mkv(0, 32'h0,        32'h0,        0,  0,  32'h0,      1, 0, 0, 32'h0,        32'h0,        0, 0, 0);

        drive_idle();
        reset = 1'b0;
        #12;
        check("reset count", 32'(count), 32'd0);
        check("reset empty", 32'(empty), 32'd1);
        check("reset st_ready", 32'(st_ready), 32'd1);
        check("reset MemWrite", 32'(MemWrite), 32'd0);
        check("reset st_err", 32'(st_err), 32'd0);
        @(negedge Clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Three stores held pending by a load, then an asynchronous reset
        // between edges discards them.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            st_valid = 1'b1; st_addr = 32'h500 + 32'(4 * i); st_data = 32'hC0 + 32'(i);
            st_con = CON_WORD; ld_valid = 1'b1; ld_addr = FAR;
        end
        @(negedge Clk);
        st_valid = 1'b0;
        #2;
        check("pre-reset count", 32'(count), 32'd3);
        check("pre-reset MemWrite", 32'(MemWrite), 32'd0);
        #1 reset = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("async reset count", 32'(count), 32'd0);
        check("async reset empty", 32'(empty), 32'd1);
        check("async reset MemWrite", 32'(MemWrite), 32'd0);
        check("async reset st_ready", 32'(st_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            #2;
            check($sformatf("in reset MemWrite c%0d", i), 32'(MemWrite), 32'd0);
        end

        // Release with a store presented: accepted on the very next edge,
        // and only that store reaches memory.
        @(negedge Clk);
        reset = 1'b1;
        st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h77; st_con = CON_WORD;
        #2;
        check("release st_ready", 32'(st_ready), 32'd1);
        check("release MemWrite", 32'(MemWrite), 32'd0);
        @(negedge Clk);
        drive_idle();
        #2;
        check("post-release count", 32'(count), 32'd1);
        check("post-release MemWrite", 32'(MemWrite), 32'd1);
        check("post-release MemAddr", MemAddr, 32'h600);
        check("post-release Memdata", Memdata, 32'h77);
        @(negedge Clk);
        #2;
        check("final count", 32'(count), 32'd0);
        check("final MemWrite", 32'(MemWrite), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
